instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Serializes one instruction into the word stream that the instruction decoder consumes: the command word first, then 0, 1 or 2 operand words.
- Sits between the program source (test sequencer or fetch/loader logic) and the decoder's data_in.
- Upstream side: valid/ready handshake carrying one whole instruction.
- Downstream side: one word per transfer, with valid/ready backpressure.

Parameters:
- BUS_WIDTH, 32, width of the stream word and of each operand; opcode field is BUS_WIDTH-4 bits.

Ports:
- clk  input  1  clock, rising edge.
- nreset  input  1  asynchronous active-low reset.
- cmd_valid  input  1  upstream instruction present.
- cmd_ready  output  1  encoder can accept an instruction.
- admin_flag  input  1  mode bit (0 user, 1 admin).
- code_type  input  3  instruction type.
- opcode  input  BUS_WIDTH-4  operation code.
- opdata0  input  BUS_WIDTH  first operand.
- opdata1  input  BUS_WIDTH  second operand.
- data_out  output  BUS_WIDTH  stream word to the decoder.
- data_valid  output  1  data_out holds a valid word.
- data_ready  input  1  sink accepts data_out this cycle.
- encoder_error  output  1  one-cycle pulse on a rejected instruction.

Behaviour:
- Clock and reset: one clock (clk); reset nreset is asynchronous, active-low.
- Reset values: cmd_ready=0 while nreset=0, otherwise 1 in IDLE; data_out=0; data_valid=0; encoder_error=0; state=IDLE.
- Reset mid-instruction drops the instruction: no further words are sent and the latched fields are cleared.
- Command word format: {admin_flag, code_type, opcode}; admin_flag is the MSB.
- Operand count by code_type:
  - CTL 3'b111: 0.
  - INT 3'b000: 0.
  - REG 3'b001: 2.
  - IMM 3'b010: 2.
  - JMP 3'b100: 1.
  - 3'b011, 3'b101, 3'b110: invalid.
- JMP opcode check: opcodes 0..4 (JMP, JE, JG, SJF, SJB) are valid; opcode > 4 is invalid.
- States:
  - IDLE: cmd_ready=1.
  - CMD, OP0, OP1: cmd_ready=0.
- Acceptance: an instruction is accepted on the rising edge where cmd_valid&&cmd_ready. All fields are latched on that edge; later input changes have no effect.
- Valid instruction:
  - Next state is CMD.
  - data_out = command word and data_valid=1 on the cycle after acceptance (latency 1).
- Invalid instruction:
  - Stays in IDLE.
  - encoder_error=1 for exactly the cycle after acceptance.
  - data_valid stays 0 and no words are emitted.
- Word advance: occurs only on an edge where data_valid&&data_ready. Otherwise data_out and data_valid hold stable for any number of stall cycles.
- Transitions on handshake:
  - CMD: to OP0 if count>=1, else to IDLE.
  - OP0: to OP1 if count==2, else to IDLE.
  - OP1: to IDLE.
- Word contents: OP0 drives latched opdata0; OP1 drives latched opdata1.
- Leaving to IDLE: data_valid=0 on the following cycle; cmd_ready=1 on the same cycle.
- No back-to-back overlap: minimum one IDLE cycle between instructions. An n-word instruction with data_ready tied high occupies n+1 cycles from acceptance to the next cmd_ready.
- data_out stays at its last value after data_valid falls; it is not zeroed.
- cmd_valid held high in IDLE with an invalid instruction is accepted again each cycle and pulses encoder_error each time.

Optional Feature:
- Macro: ENCODER_ADMIN_CHECK_EN.
- Defined: CTL or INT type with admin_flag=0 is treated as invalid (error pulse, no words emitted).
- Undefined: admin_flag is passed through unchecked.

Test Plan:
- IMM ADD, admin=0, opdata0=1, opdata1=4, data_ready=1 -> data_out sequence 0x20000001, 0x00000001, 0x00000004 on three consecutive cycles; cmd_ready back to 1 on the 4th cycle.
- INT opcode 1, admin=1 -> single word 0x80000001; no operand words.
- JMP JG, admin=1, opdata0=2 -> 0xC0000002 then 0x00000002; then 0xC0000005 (JMP opcode 5) -> encoder_error one-cycle pulse, data_valid stays 0.
- Type 3'b101 SJB -> encoder_error pulse, data_valid=0, state remains IDLE, cmd_ready stays 1.
- REG, opdata0=7, opdata1=9, data_ready low 3 cycles during OP0 -> 0x00000007 held stable for 4 cycles, then 0x00000009; inputs changed after acceptance do not affect output.
- nreset asserted during OP0 of IMM -> data_valid=0 immediately; after release, cmd_ready=1 and no residual words. With ENCODER_ADMIN_CHECK_EN: CTL with admin=0 -> error pulse; without it -> 0x70000000 emitted.

Source files
------------

// File: rtl/instr_encoder.sv
// Serializes one instruction into a command word plus 0-2 operand words; optional admin check via ENCODER_ADMIN_CHECK_EN.
// Latency: first word is valid the cycle after acceptance; rejected instructions pulse encoder_error instead.
// Backpressure: words advance only on data_valid && data_ready; cmd_ready is high only while idle.
module instr_encoder #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 admin_flag,
    input  logic [2:0]           code_type,
    input  logic [BUS_WIDTH-5:0] opcode,
    input  logic [BUS_WIDTH-1:0] opdata0,
    input  logic [BUS_WIDTH-1:0] opdata1,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 encoder_error
);
    localparam int OPC_W = BUS_WIDTH - 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_OP0  = 2'd2;
    localparam logic [1:0] S_OP1  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] op0_q, op0_d;
    logic [BUS_WIDTH-1:0] op1_q, op1_d;
    logic [BUS_WIDTH-1:0] dout_q, dout_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;

    logic                 inst_ok;
    logic [1:0]           inst_cnt;
    logic                 word_hs;

    // Decode of the instruction currently offered upstream.
    always_comb begin
        inst_ok  = 1'b0;
        inst_cnt = 2'd0;
        case (code_type)
            3'b111, 3'b000: begin
`ifdef ENCODER_ADMIN_CHECK_EN
                inst_ok = admin_flag;
`else
                inst_ok = 1'b1;
`endif
            end
            3'b001, 3'b010: begin
                inst_ok  = 1'b1;
                inst_cnt = 2'd2;
            end
            3'b100: begin
                inst_ok  = (opcode <= OPC_W'(4));
                inst_cnt = 2'd1;
            end
            default: inst_ok = 1'b0;
        endcase
    end

    assign word_hs = vld_q && data_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        dout_d  = dout_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (inst_ok) begin
                        state_d = S_CMD;
                        cnt_d   = inst_cnt;
                        op0_d   = opdata0;
                        op1_d   = opdata1;
                        dout_d  = {admin_flag, code_type, opcode};
                        vld_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CMD: begin
                if (word_hs) begin
                    if (cnt_q != 2'd0) begin
                        state_d = S_OP0;
                        dout_d  = op0_q;
                    end else begin
                        state_d = S_IDLE;
                        vld_d   = 1'b0;
                    end
                end
            end
            S_OP0: begin
                if (word_hs) begin
                    if (cnt_q == 2'd2) begin
                        state_d = S_OP1;
                        dout_d  = op1_q;
                    end else begin
                        state_d = S_IDLE;
                        vld_d   = 1'b0;
                    end
                end
            end
            default: begin
                if (word_hs) begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                end
            end
        endcase
    end

    // Reset drops any in-flight instruction along with its latched operands.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            op0_q   <= '0;
            op1_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready     = nreset && (state_q == S_IDLE);
    assign data_out      = dout_q;
    assign data_valid    = vld_q;
    assign encoder_error = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed scenarios plus randomized instructions against a table-driven model.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        nreset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        admin_flag;
    logic [2:0]  code_type;
    logic [27:0] opcode;
    logic [31:0] opdata0;
    logic [31:0] opdata1;
    logic [31:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        encoder_error;

    int checks = 0;
    int errors = 0;
    bit rdy_rand = 1'b0;

    typedef struct {
        bit          is_err;
        logic [31:0] w;
    } ev_t;
    ev_t exp_q[$];

    instr_encoder #(.BUS_WIDTH(32)) dut (
        .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .admin_flag(admin_flag), .code_type(code_type), .opcode(opcode),
        .opdata0(opdata0), .opdata1(opdata1), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready), .encoder_error(encoder_error)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference: operand count per instruction, -1 when rejected.
    function automatic int n_ops(bit adm, logic [2:0] t, logic [27:0] opc);
        case (t)
            3'b111, 3'b000: begin
`ifdef ENCODER_ADMIN_CHECK_EN
                return adm ? 0 : -1;
`else
                return (adm || !adm) ? 0 : -1;
`endif
            end
            3'b001, 3'b010: return 2;
            3'b100:         return (opc <= 28'd4) ? 1 : -1;
            default:        return -1;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_expect(bit adm, logic [2:0] t, logic [27:0] opc, logic [31:0] d0, logic [31:0] d1);
        int n;
        n = n_ops(adm, t, opc);
        if (n < 0) begin
            exp_q.push_back('{1'b1, 32'h0});
        end else begin
            exp_q.push_back('{1'b0, {adm, t, opc}});
            if (n >= 1) exp_q.push_back('{1'b0, d0});
            if (n >= 2) exp_q.push_back('{1'b0, d1});
        end
    endtask

    // Offer one instruction; returns at posedge+1 after it is accepted, with inputs scrambled.
    task automatic issue(bit adm, logic [2:0] t, logic [27:0] opc, logic [31:0] d0, logic [31:0] d1);
        bit got = 1'b0;
        admin_flag = adm; code_type = t; opcode = opc; opdata0 = d0; opdata1 = d1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: actual=cmd_ready_low required=cmd_ready_high");
        end else begin
            push_expect(adm, t, opc, d0, d1);
            @(posedge clk);
        end
        #1;
        cmd_valid  = 1'b0;
        admin_flag = 1'($urandom);
        code_type  = 3'($urandom);
        opcode     = 28'($urandom);
        opdata0    = $urandom;
        opdata1    = $urandom;
    endtask

    task automatic pop_chk(bit is_err, logic [31:0] w);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: actual=%h required=none at %0t", is_err ? "error_pulse" : "word", w, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.is_err != is_err || (!is_err && e.w !== w)) begin
                errors++;
                $display("FAIL scoreboard: actual=%s/%h required=%s/%h at %0t",
                         is_err ? "err" : "word", w, e.is_err ? "err" : "word", e.w, $time);
            end
        end
    endtask

    // Monitor: pops expected events and enforces hold-during-stall.
    bit          stall_prev = 1'b0;
    logic [31:0] held_w;
    always @(negedge clk) begin
        if (!nreset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_hold_valid", {31'd0, data_valid}, 32'd1);
                chk("stall_hold_data", data_out, held_w);
            end
            if (encoder_error) pop_chk(1'b1, 32'h0);
            if (data_valid && data_ready) pop_chk(1'b0, data_out);
            stall_prev = data_valid && !data_ready;
            held_w     = data_out;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) data_ready = ($urandom_range(0, 9) < 7);
    end

    initial begin
        nreset = 1'b0; cmd_valid = 1'b0; admin_flag = 1'b0; code_type = 3'd0;
        opcode = '0; opdata0 = '0; opdata1 = '0; data_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_error", {31'd0, encoder_error}, 32'd0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // IMM ADD with ready high: three words, cmd_ready back on the 4th cycle
        issue(1'b0, 3'b010, 28'd1, 32'd1, 32'd4);
        chk("imm_w0", data_out, 32'h2000_0001);
        chk("imm_rdy_c1", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        chk("imm_w1", data_out, 32'h0000_0001);
        @(posedge clk); #1;
        chk("imm_w2", data_out, 32'h0000_0004);
        chk("imm_rdy_c3", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        chk("imm_rdy_c4", {31'd0, cmd_ready}, 32'd1);
        chk("imm_vld_c4", {31'd0, data_valid}, 32'd0);
        chk("imm_dout_kept", data_out, 32'h0000_0004);

        // INT admin single word
        issue(1'b1, 3'b000, 28'd1, 32'hdead_beef, 32'hcafe_f00d);
        chk("int_w0", data_out, 32'h8000_0001);
        @(posedge clk); #1;
        chk("int_done_vld", {31'd0, data_valid}, 32'd0);

        // JMP JG then invalid JMP opcode 5
        issue(1'b1, 3'b100, 28'd2, 32'd2, 32'd77);
        chk("jmp_w0", data_out, 32'hC000_0002);
        @(posedge clk); #1;
        chk("jmp_w1", data_out, 32'h0000_0002);
        issue(1'b1, 3'b100, 28'd5, 32'd3, 32'd3);
        chk("jmp5_err", {31'd0, encoder_error}, 32'd1);
        chk("jmp5_vld", {31'd0, data_valid}, 32'd0);
        @(posedge clk); #1;
        chk("jmp5_err_pulse", {31'd0, encoder_error}, 32'd0);

        // Invalid type 3'b101
        issue(1'b1, 3'b101, 28'd4, 32'd0, 32'd0);
        chk("t101_err", {31'd0, encoder_error}, 32'd1);
        chk("t101_vld", {31'd0, data_valid}, 32'd0);
        chk("t101_rdy", {31'd0, cmd_ready}, 32'd1);

        // Invalid held on cmd_valid: accepted and rejected each cycle
        admin_flag = 1'b0; code_type = 3'b011; opcode = 28'd0; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_invalid_rdy", {31'd0, cmd_ready}, 32'd1);
            exp_q.push_back('{1'b1, 32'h0});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;

        // REG with stall during OP0; inputs scrambled after acceptance
        issue(1'b0, 3'b001, 28'd3, 32'd7, 32'd9);
        chk("reg_w0", data_out, 32'h1000_0003);
        @(posedge clk); #1;
        data_ready = 1'b0;
        chk("reg_op0_c0", data_out, 32'd7);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reg_op0_stall", data_out, 32'd7);
        end
        data_ready = 1'b1;
        @(posedge clk); #1;
        chk("reg_op1", data_out, 32'd9);
        @(posedge clk); #1;

        // Reset during OP0 of IMM
        issue(1'b0, 3'b010, 28'd6, 32'h1111_1111, 32'h2222_2222);
        @(posedge clk); #2;
        data_ready = 1'b0;
        #1;
        nreset = 1'b0;
        #1;
        chk("rst_mid_vld", {31'd0, data_valid}, 32'd0);
        chk("rst_mid_rdy", {31'd0, cmd_ready}, 32'd0);
        chk("rst_mid_dout", data_out, 32'd0);
        exp_q.delete();
        data_ready = 1'b1;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel_rdy", {31'd0, cmd_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_residual", {31'd0, data_valid}, 32'd0);

        // CTL with admin=0: rejected only when the admin check is built in
        issue(1'b0, 3'b111, 28'd0, 32'd0, 32'd0);
`ifdef ENCODER_ADMIN_CHECK_EN
        chk("ctl_user_err", {31'd0, encoder_error}, 32'd1);
`else
        chk("ctl_user_w0", data_out, 32'h7000_0000);
`endif
        @(posedge clk); #1;

        // Randomized instructions with random backpressure
        rdy_rand = 1'b1;
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  t;
            logic [27:0] o;
            t = 3'($urandom);
            o = (t == 3'b100) ? 28'($urandom_range(0, 7)) : 28'($urandom);
            issue(1'($urandom), t, o, $urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && cmd_ready) break;
        end
        repeat (5) @(negedge clk);
        chk("drain_pending", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
